// File: rtl/vector_regfile_pm.sv
// rtl/vector_regfile_pm.sv - vector register file with per-element write mask, forwarding and bulk clear
// Register 0 reads as zero; the clear FSM sweeps reg 1..NREGS-1 while blocking writes.
module vector_regfile_pm #(
   parameter int ELEM_W = 32,
   parameter int VLEN   = 8,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS),
   localparam int DW    = VLEN * ELEM_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [VLEN-1:0] we_mask,
   input  logic [AW-1:0] write_addr,
   input  logic [DW-1:0] write_vec,
   input  logic [AW-1:0] read_addr_a,
   input  logic [AW-1:0] read_addr_b,
   output logic [DW-1:0] read_vec_a,
   output logic [DW-1:0] read_vec_b,
   output logic          wr_ready,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t        state;
   logic [AW-1:0] ptr;
   logic [DW-1:0] regs [NREGS];
   logic          wr_acc;

   assign clr_busy = (state == SWEEP);
   assign clr_done = (state == DONE);
   assign wr_ready = !clr_busy;
   assign wr_acc   = we && wr_ready && (write_addr != '0);

   // Forward only the masked elements of an accepted write; reg 0 always reads zero.
   function automatic logic [DW-1:0] read_port(input logic [DW-1:0] stored,
                                               input logic [AW-1:0] addr);
      logic [DW-1:0] v;
      v = stored;
      if (BYPASS != 0 && wr_acc && write_addr == addr) begin
         for (int e = 0; e < VLEN; e++) begin
            if (we_mask[e]) v[e*ELEM_W +: ELEM_W] = write_vec[e*ELEM_W +: ELEM_W];
         end
      end
      if (addr == '0) v = '0;
      return v;
   endfunction

   assign read_vec_a = read_port(regs[read_addr_a], read_addr_a);
   assign read_vec_b = read_port(regs[read_addr_b], read_addr_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else begin
         if (state == SWEEP) regs[ptr] <= '0;
         if (wr_acc) begin
            for (int e = 0; e < VLEN; e++) begin
               if (we_mask[e]) regs[write_addr][e*ELEM_W +: ELEM_W] <= write_vec[e*ELEM_W +: ELEM_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= AW'(1);
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= SWEEP;
                  ptr   <= AW'(1);
               end
            end
            SWEEP: begin
               ptr <= ptr + AW'(1);
               if (ptr == AW'(NREGS - 1)) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               ptr   <= AW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
